// File: rtl/mc_main_control_if.sv
// mc_main_control_if
//   Control bundle between the multi-cycle MIPS main control FSM and the
//   datapath / ALU control decoder.
//
//   Signals:
//     op, mem_ready           datapath -> controller (opcode, memory done)
//     PCWrite, PCWriteCond    PC load enables
//     IorD, MemRead, MemWrite memory address select and requests
//     MemtoReg, IRWrite       write-back select, instruction register load
//     RegDst, RegWrite        register file destination select / write
//     ALUSrcA, ALUSrcB        ALU operand selects
//     ALUOp                   to the ALU control decoder
//     PCSource                next-PC source select
//     instr_done              last-cycle-of-instruction pulse
//     illegal_op              sticky trap flag (only with ILLEGAL_OP_TRAP_EN)
//
//   Modports:
//     master : the controller (drives the controls, reads op/mem_ready)
//     slave  : the datapath side
interface mc_main_control_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       instr_done;
`ifdef ILLEGAL_OP_TRAP_EN
  logic       illegal_op;
`endif

  modport master (
`ifdef ILLEGAL_OP_TRAP_EN
    output illegal_op,
`endif
    input  op, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
           IRWrite, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           instr_done
  );

  modport slave (
`ifdef ILLEGAL_OP_TRAP_EN
    input  illegal_op,
`endif
    output op, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
           IRWrite, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           instr_done
  );
endinterface

// File: rtl/mc_main_control.sv
// mc_main_control
//   Main control Moore FSM for the multi-cycle MIPS datapath. Sequences
//   R-type, lw, sw, beq, addi and j, drives every datapath enable/select and
//   the 2-bit ALUOp consumed by the ALU control decoder. Memory accesses
//   (fetch, lw read, sw write) stall on mem_ready.
//
//   Ports:
//     clk    in  rising-edge clock
//     rst_n  in  asynchronous active-low reset (forces S_RESET at once)
//     ctl    mc_main_control_if.master: op/mem_ready in, all controls out
//
//   Optional feature (macro ILLEGAL_OP_TRAP_EN):
//     defined   - unknown opcode in decode parks the FSM in S_TRAP with all
//                 controls low and illegal_op high until reset.
//     undefined - unknown opcode falls back to fetch (2-cycle NOP, no
//                 instr_done); no S_TRAP state, no illegal_op signal.
module mc_main_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input logic                clk,
  input logic                rst_n,
  mc_main_control_if.master  ctl
);

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWR,
    S_MEMWB,
    S_RTYPEEX,
    S_RTYPEWB,
    S_BEQEX,
    S_ADDIEX,
    S_ADDIWB,
    S_JEX
`ifdef ILLEGAL_OP_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       irwrite;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       instr_done;
  } ctrl_t;

  state_t state, nxt;
  ctrl_t  c;

  // op is only looked at in decode, so the lw/sw choice made there is
  // remembered for the address state; op may change after decode.
  logic is_sw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RESET;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 is_sw <= 1'b0;
    else if (state == S_DECODE) is_sw <= (ctl.op == OP_SW);
  end

  always_comb begin
    nxt = state;
    c   = '0;
    case (state)
      S_RESET: nxt = S_FETCH;

      // PC+4 and IR load fire only in the cycle memory completes; since
      // that same cycle leaves fetch, the PC advances exactly once.
      S_FETCH: begin
        c.memread = 1'b1;
        c.alusrcb = 2'b01;
        c.pcwrite = ctl.mem_ready;
        c.irwrite = ctl.mem_ready;
        if (ctl.mem_ready) nxt = S_DECODE;
      end

      // ALU precomputes the branch target PC + (imm<<2) into ALUOut.
      S_DECODE: begin
        c.alusrcb = 2'b11;
        case (ctl.op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_RTYPEEX;
          OP_BEQ:       nxt = S_BEQEX;
          OP_ADDI:      nxt = S_ADDIEX;
          OP_J:         nxt = S_JEX;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      nxt = S_TRAP;
`else
          default:      nxt = S_FETCH;
`endif
        endcase
      end

      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        nxt       = is_sw ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
        if (ctl.mem_ready) nxt = S_MEMWB;
      end

      // Request stays asserted through the stall; the instruction only
      // completes in the cycle the write is accepted.
      S_MEMWR: begin
        c.memwrite   = 1'b1;
        c.iord       = 1'b1;
        c.instr_done = ctl.mem_ready;
        if (ctl.mem_ready) nxt = S_FETCH;
      end

      S_MEMWB: begin
        c.memtoreg   = 1'b1;
        c.regwrite   = 1'b1;
        c.instr_done = 1'b1;
        nxt          = S_FETCH;
      end

      S_RTYPEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
        nxt       = S_RTYPEWB;
      end

      S_RTYPEWB: begin
        c.regdst     = 1'b1;
        c.regwrite   = 1'b1;
        c.instr_done = 1'b1;
        nxt          = S_FETCH;
      end

      // Subtract A-B; PC loads the precomputed target from ALUOut on zero.
      S_BEQEX: begin
        c.alusrca     = 1'b1;
        c.aluop       = 2'b01;
        c.pcwritecond = 1'b1;
        c.pcsource    = 2'b01;
        c.instr_done  = 1'b1;
        nxt           = S_FETCH;
      end

      S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        nxt       = S_ADDIWB;
      end

      S_ADDIWB: begin
        c.regwrite   = 1'b1;
        c.instr_done = 1'b1;
        nxt          = S_FETCH;
      end

      S_JEX: begin
        c.pcwrite    = 1'b1;
        c.pcsource   = 2'b10;
        c.instr_done = 1'b1;
        nxt          = S_FETCH;
      end

`ifdef ILLEGAL_OP_TRAP_EN
      // Parked until reset; all controls stay low.
      S_TRAP: nxt = S_TRAP;
`endif

      default: nxt = S_RESET;
    endcase
  end

  assign ctl.PCWrite     = c.pcwrite;
  assign ctl.PCWriteCond = c.pcwritecond;
  assign ctl.IorD        = c.iord;
  assign ctl.MemRead     = c.memread;
  assign ctl.MemWrite    = c.memwrite;
  assign ctl.MemtoReg    = c.memtoreg;
  assign ctl.IRWrite     = c.irwrite;
  assign ctl.RegDst      = c.regdst;
  assign ctl.RegWrite    = c.regwrite;
  assign ctl.ALUSrcA     = c.alusrca;
  assign ctl.ALUSrcB     = c.alusrcb;
  assign ctl.ALUOp       = c.aluop;
  assign ctl.PCSource    = c.pcsource;
  assign ctl.instr_done  = c.instr_done;
`ifdef ILLEGAL_OP_TRAP_EN
  // Sticky by construction: S_TRAP is only left through reset.
  assign ctl.illegal_op  = (state == S_TRAP);
`endif

endmodule

// File: tb/tb_mc_main_control.sv
// tb_mc_main_control
//   Directed bench for mc_main_control: walks lw, R-type, beq, j, addi and
//   sw (with write and fetch stalls), an asynchronous reset mid-instruction
//   and an unknown opcode. Outputs are packed into one vector and compared
//   against hand-built expected vectors a couple of ns after each edge.
module tb_mc_main_control;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mc_main_control_if ifc();
  mc_main_control dut (.clk(clk), .rst_n(rst_n), .ctl(ifc.master));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegDst,
  //  RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0],instr_done}
  logic [16:0] obs;
  assign obs = {ifc.PCWrite, ifc.PCWriteCond, ifc.IorD, ifc.MemRead,
                ifc.MemWrite, ifc.MemtoReg, ifc.IRWrite, ifc.RegDst,
                ifc.RegWrite, ifc.ALUSrcA, ifc.ALUSrcB, ifc.ALUOp,
                ifc.PCSource, ifc.instr_done};

  function automatic logic [16:0] mk(input int pcw, pcwc, iord, mr, mw, m2r,
                                     irw, rd, rw, sa, sb, aop, pcs, done);
    return {pcw[0], pcwc[0], iord[0], mr[0], mw[0], m2r[0], irw[0], rd[0],
            rw[0], sa[0], sb[1:0], aop[1:0], pcs[1:0], done[0]};
  endfunction

  logic [16:0] e_zero, e_fetch_r, e_fetch_s, e_dec, e_adr, e_memrd;
  logic [16:0] e_memwr_s, e_memwr_r, e_memwb, e_rex, e_rwb, e_beq, e_awb, e_jex;

  task automatic chk(input string tag, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then apply the inputs seen during the new state.
  task automatic step(input logic mr, input logic [5:0] o);
    @(posedge clk);
    #1;
    ifc.mem_ready = mr;
    ifc.op = o;
    #1;
  endtask

  initial begin
    //                 pcw pcwc iord mr mw m2r irw rd rw sa  sb     aop    pcs  done
    e_zero    = '0;
    e_fetch_r = mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
    e_fetch_s = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
    e_dec     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0);
    e_adr     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
    e_memrd   = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    e_memwr_s = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    e_memwr_r = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1);
    e_memwb   = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1);
    e_rex     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
    e_rwb     = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 1);
    e_beq     = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 1);
    e_awb     = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1);
    e_jex     = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1);

    ifc.op = OP_LW;
    ifc.mem_ready = 1'b1;
    #2 chk("reset_asserted", e_zero);
`ifdef ILLEGAL_OP_TRAP_EN
    checks++;
    assert (ifc.illegal_op === 1'b0) else begin
      failures++;
      $error("FAIL illegal_op_reset observed=%b expected=0", ifc.illegal_op);
    end
`endif
    #10 rst_n = 1'b1;                      // t=12, between edges
    #1 chk("s_reset_released", e_zero);

    // lw; op changes during memadr and must not redirect it
    step(1, OP_LW);    chk("lw_fetch", e_fetch_r);
    step(1, OP_LW);    chk("lw_decode", e_dec);
    step(1, OP_RTYPE); chk("lw_memadr", e_adr);
    step(1, OP_RTYPE); chk("lw_memrd", e_memrd);
    step(1, OP_RTYPE); chk("lw_memwb", e_memwb);

    // R-type
    step(1, OP_RTYPE); chk("r_fetch", e_fetch_r);
    step(1, OP_RTYPE); chk("r_decode", e_dec);
    step(1, OP_RTYPE); chk("r_ex", e_rex);
    step(1, OP_BEQ);   chk("r_wb", e_rwb);

    // beq
    step(1, OP_BEQ);   chk("beq_fetch", e_fetch_r);
    step(1, OP_BEQ);   chk("beq_decode", e_dec);
    step(1, OP_J);     chk("beq_ex", e_beq);

    // j
    step(1, OP_J);     chk("j_fetch", e_fetch_r);
    step(1, OP_J);     chk("j_decode", e_dec);
    step(1, OP_ADDI);  chk("j_ex", e_jex);

    // addi
    step(1, OP_ADDI);  chk("addi_fetch", e_fetch_r);
    step(1, OP_ADDI);  chk("addi_decode", e_dec);
    step(1, OP_ADDI);  chk("addi_ex", e_adr);
    step(1, OP_SW);    chk("addi_wb", e_awb);

    // sw with a 3-cycle write stall, then a 2-cycle fetch stall
    step(1, OP_SW);    chk("sw_fetch", e_fetch_r);
    step(1, OP_SW);    chk("sw_decode", e_dec);
    step(0, OP_LW);    chk("sw_memadr", e_adr);
    step(0, OP_LW);    chk("sw_memwr_stall0", e_memwr_s);
    step(0, OP_LW);    chk("sw_memwr_stall1", e_memwr_s);
    step(0, OP_LW);    chk("sw_memwr_stall2", e_memwr_s);
    step(1, OP_LW);    chk("sw_memwr_done", e_memwr_r);
    step(0, OP_RTYPE); chk("fetch_stall0", e_fetch_s);
    step(0, OP_RTYPE); chk("fetch_stall1", e_fetch_s);
    step(1, OP_RTYPE); chk("fetch_go", e_fetch_r);
    step(1, OP_RTYPE); chk("r2_decode", e_dec);
    step(1, OP_RTYPE); chk("r2_ex", e_rex);

    // asynchronous reset in the middle of R-type execute
    #1 rst_n = 1'b0;
    #1 chk("rst_async_no_edge", e_zero);
    step(1, OP_RTYPE); chk("rst_held", e_zero);
    rst_n = 1'b1;
    #1 chk("rst_release_idle", e_zero);
    step(1, OP_BAD);   chk("post_rst_fetch", e_fetch_r);
    step(1, OP_BAD);   chk("post_rst_decode_no_pcw", e_dec);

    // unknown opcode
`ifdef ILLEGAL_OP_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      step(1, OP_BAD); chk("trap_outputs", e_zero);
      checks++;
      assert (ifc.illegal_op === 1'b1) else begin
        failures++;
        $error("FAIL illegal_op_set observed=%b expected=1", ifc.illegal_op);
      end
    end
`else
    step(1, OP_BAD);   chk("bad_op_back_to_fetch", e_fetch_r);
    step(1, OP_BAD);   chk("bad_op_decode_again", e_dec);
    step(1, OP_RTYPE); chk("bad_op_refetch", e_fetch_r);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
